// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - state encodings, lamp bit positions and lamp decode shared by traffic_light_fsm
package tl_pkg;

  typedef enum logic [2:0] {
    ST_ALLY  = 3'd0,
    ST_R1Y2  = 3'd1,
    ST_G1R2  = 3'd2,
    ST_Y1R2  = 3'd3,
    ST_R1G2  = 3'd4,
    ST_FLASH = 3'd5
  } tl_state_e;

  // Lamp vectors are {red,yellow,green}.
  localparam int LAMP_RED_BIT = 2;
  localparam int LAMP_YEL_BIT = 1;
  localparam int LAMP_GRN_BIT = 0;

  localparam logic [2:0] LAMP_RED = 3'(1 << LAMP_RED_BIT);
  localparam logic [2:0] LAMP_YEL = 3'(1 << LAMP_YEL_BIT);
  localparam logic [2:0] LAMP_GRN = 3'(1 << LAMP_GRN_BIT);
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {light1, light2} for a state; flash_on selects the lit half of night flash.
  function automatic logic [5:0] lamps_for(input tl_state_e s, input logic flash_on);
    case (s)
      ST_ALLY:  lamps_for = {LAMP_YEL, LAMP_YEL};
      ST_R1Y2:  lamps_for = {LAMP_RED, LAMP_YEL};
      ST_G1R2:  lamps_for = {LAMP_GRN, LAMP_RED};
      ST_Y1R2:  lamps_for = {LAMP_YEL, LAMP_RED};
      ST_R1G2:  lamps_for = {LAMP_RED, LAMP_GRN};
      ST_FLASH: lamps_for = flash_on ? {LAMP_YEL, LAMP_YEL} : {LAMP_OFF, LAMP_OFF};
      default:  lamps_for = {LAMP_YEL, LAMP_YEL};
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// rtl/traffic_light_fsm_if.sv - control inputs and lamp/status outputs of traffic_light_fsm
interface traffic_light_fsm_if #(
  parameter int CNT_W = 12
);

  logic             tick;
  logic             night;
  logic [1:0]       ped_req;
  logic [2:0]       light1;
  logic [2:0]       light2;
  logic [2:0]       phase;
  logic [CNT_W-1:0] remain;
  logic [1:0]       ped_pend;

  modport master (
    output tick, night, ped_req,
    input  light1, light2, phase, remain, ped_pend
  );

  modport slave (
    input  tick, night, ped_req,
    output light1, light2, phase, remain, ped_pend
  );

endinterface

// File: rtl/traffic_light_fsm_ped.sv
// rtl/traffic_light_fsm_ped.sv - pedestrian request latch; clear wins over a same-edge request
module traffic_light_fsm_ped (
  input  logic       clk,
  input  logic       ret,
  input  logic [1:0] req,
  input  logic       ignore,
  input  logic [1:0] clr,
  output logic [1:0] pend
);

  logic [1:0] pend_d;
  logic [1:0] pend_q;

  always_comb begin
    pend_d = (pend_q | (ignore ? 2'b00 : req)) & ~clr;
  end

  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      pend_q <= 2'b00;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-direction traffic light controller with pedestrian
// early-exit and night flash mode; all phase timing advances on tick.
module traffic_light_fsm
  import tl_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int T_ALLY  = 250,
  parameter int T_Y     = 250,
  parameter int T_G1    = 2500,
  parameter int T_G2    = 2250,
  parameter int T_MIN   = 500,
  parameter int T_FLASH = 50
) (
  input logic               clk,
  input logic               ret,
  traffic_light_fsm_if.slave bus
);

  function automatic bit t_ok(input int t);
    return (t >= 1) && (longint'(t) < (longint'(1) << CNT_W));
  endfunction

  localparam bit PARAMS_OK = (CNT_W >= 1) && (CNT_W <= 32) &&
                             t_ok(T_ALLY) && t_ok(T_Y) && t_ok(T_G1) && t_ok(T_G2) &&
                             t_ok(T_MIN) && t_ok(T_FLASH) &&
                             (T_MIN <= T_G1) && (T_MIN <= T_G2);

  if (!PARAMS_OK) begin : g_param_check
    $error("traffic_light_fsm: timing parameters out of range");
  end

  localparam logic [CNT_W-1:0] ALLY_M1  = CNT_W'(T_ALLY - 1);
  localparam logic [CNT_W-1:0] Y_M1     = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] G1_M1    = CNT_W'(T_G1 - 1);
  localparam logic [CNT_W-1:0] G2_M1    = CNT_W'(T_G2 - 1);
  localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(T_MIN - 1);
  localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(T_FLASH - 1);

  // Count value on which the current state's last tick falls.
  function automatic logic [CNT_W-1:0] last_tick(input tl_state_e s);
    case (s)
      ST_ALLY:  last_tick = ALLY_M1;
      ST_R1Y2:  last_tick = Y_M1;
      ST_G1R2:  last_tick = G1_M1;
      ST_Y1R2:  last_tick = Y_M1;
      ST_R1G2:  last_tick = G2_M1;
      ST_FLASH: last_tick = FLASH_M1;
      default:  last_tick = ALLY_M1;
    endcase
  endfunction

  tl_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flash_q, flash_d;
  logic [2:0]       light1_q, light1_d;
  logic [2:0]       light2_q, light2_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  tl_state_e        nxt;
  logic             force_exit;
  logic             legal;
  logic [1:0]       ped_clr;
  logic             ped_ignore;
  logic [1:0]       ped_pend;

  assign ped_ignore = (state_q == ST_FLASH);

  traffic_light_fsm_ped u_ped (
    .clk    (clk),
    .ret    (ret),
    .req    (bus.ped_req),
    .ignore (ped_ignore),
    .clr    (ped_clr),
    .pend   (ped_pend)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    flash_d    = flash_q;
    ped_clr    = 2'b00;
    nxt        = state_q;
    force_exit = 1'b0;
    legal      = 1'b1;

    case (state_q)
      ST_ALLY:  nxt = ST_R1Y2;
      ST_R1Y2:  nxt = ST_G1R2;
      ST_G1R2: begin
        nxt        = ST_Y1R2;
        force_exit = ped_pend[0] && (count_q >= MIN_M1);
      end
      ST_Y1R2:  nxt = ST_R1G2;
      ST_R1G2: begin
        nxt        = ST_R1Y2;
        force_exit = ped_pend[1] && (count_q >= MIN_M1);
      end
      ST_FLASH: nxt = ST_FLASH;
      default:  legal = 1'b0;
    endcase

    if (!legal) begin
      state_d = ST_ALLY;
      count_d = '0;
      flash_d = 1'b1;
      ped_clr = 2'b11;
    end else if (bus.tick) begin
      if (state_q == ST_FLASH) begin
        if (!bus.night) begin
          state_d = ST_ALLY;
          count_d = '0;
        end else if (count_q == FLASH_M1) begin
          count_d = '0;
          flash_d = ~flash_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (bus.night) begin
        // Night overrides both expiry and any pending pedestrian exit.
        state_d = ST_FLASH;
        count_d = '0;
        flash_d = 1'b1;
        ped_clr = 2'b11;
      end else if ((count_q == last_tick(state_q)) || force_exit) begin
        state_d = nxt;
        count_d = '0;
        ped_clr = {state_q == ST_R1G2, state_q == ST_G1R2};
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    {light1_d, light2_d} = lamps_for(state_d, flash_d);
    remain_d = (state_d == ST_FLASH) ? '0 : (last_tick(state_d) - count_d);
  end

  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      state_q  <= ST_ALLY;
      count_q  <= '0;
      flash_q  <= 1'b1;
      light1_q <= LAMP_YEL;
      light2_q <= LAMP_YEL;
      remain_q <= ALLY_M1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      flash_q  <= flash_d;
      light1_q <= light1_d;
      light2_q <= light2_d;
      remain_q <= remain_d;
    end
  end

  assign bus.light1   = light1_q;
  assign bus.light2   = light2_q;
  assign bus.phase    = state_q;
  assign bus.remain   = remain_q;
  assign bus.ped_pend = ped_pend;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - scoreboard bench for traffic_light_fsm with a phase-table reference model
module tb_traffic_light_fsm;
  import tl_pkg::*;

  localparam int CW      = 8;
  localparam int P_ALLY  = 2;
  localparam int P_Y     = 3;
  localparam int P_G1    = 10;
  localparam int P_G2    = 8;
  localparam int P_MIN   = 4;
  localparam int P_FLASH = 2;

  logic clk = 1'b0;
  logic ret = 1'b1;

  traffic_light_fsm_if #(.CNT_W(CW)) bus ();

  traffic_light_fsm #(
    .CNT_W(CW), .T_ALLY(P_ALLY), .T_Y(P_Y), .T_G1(P_G1),
    .T_G2(P_G2), .T_MIN(P_MIN), .T_FLASH(P_FLASH)
  ) dut (
    .clk (clk),
    .ret (ret),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int l1;
    int l2;
    int rem;
    int pend;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Reference model: which phase we are in and how many ticks of it have elapsed.
  tl_state_e m_st;
  int        m_el;
  bit        m_fl;
  bit [1:0]  m_pend;

  function automatic int dur(input tl_state_e s);
    case (s)
      ST_ALLY: return P_ALLY;
      ST_R1Y2: return P_Y;
      ST_G1R2: return P_G1;
      ST_Y1R2: return P_Y;
      ST_R1G2: return P_G2;
      default: return P_FLASH;
    endcase
  endfunction

  function automatic tl_state_e succ(input tl_state_e s);
    case (s)
      ST_ALLY: return ST_R1Y2;
      ST_R1Y2: return ST_G1R2;
      ST_G1R2: return ST_Y1R2;
      ST_Y1R2: return ST_R1G2;
      default: return ST_R1Y2;
    endcase
  endfunction

  function automatic void m_reset();
    m_st   = ST_ALLY;
    m_el   = 0;
    m_fl   = 1'b1;
    m_pend = 2'b00;
  endfunction

  function automatic void m_step(input bit t, input bit n, input bit [1:0] r);
    bit [1:0] clr;
    bit       in_flash;
    clr      = 2'b00;
    in_flash = (m_st == ST_FLASH);
    if (t) begin
      if (in_flash) begin
        if (!n) begin
          m_st = ST_ALLY;
          m_el = 0;
        end else begin
          m_el++;
          if (m_el == P_FLASH) begin
            m_el = 0;
            m_fl = ~m_fl;
          end
        end
      end else if (n) begin
        m_st = ST_FLASH;
        m_el = 0;
        m_fl = 1'b1;
        clr  = 2'b11;
      end else begin
        m_el++;
        if (m_el == dur(m_st) ||
            (m_st == ST_G1R2 && m_pend[0] && m_el >= P_MIN) ||
            (m_st == ST_R1G2 && m_pend[1] && m_el >= P_MIN)) begin
          if (m_st == ST_G1R2) clr[0] = 1'b1;
          if (m_st == ST_R1G2) clr[1] = 1'b1;
          m_st = succ(m_st);
          m_el = 0;
        end
      end
    end
    m_pend = (m_pend & ~clr) | ((in_flash ? 2'b00 : r) & ~clr);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.ph = int'(m_st);
    case (m_st)
      ST_ALLY:  begin e.l1 = 3'b010; e.l2 = 3'b010; end
      ST_R1Y2:  begin e.l1 = 3'b100; e.l2 = 3'b010; end
      ST_G1R2:  begin e.l1 = 3'b001; e.l2 = 3'b100; end
      ST_Y1R2:  begin e.l1 = 3'b010; e.l2 = 3'b100; end
      ST_R1G2:  begin e.l1 = 3'b100; e.l2 = 3'b001; end
      default:  begin e.l1 = m_fl ? 3'b010 : 3'b000; e.l2 = e.l1; end
    endcase
    e.rem  = (m_st == ST_FLASH) ? 0 : dur(m_st) - 1 - m_el;
    e.pend = int'(m_pend);
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc_n, got, want);
    end
  endtask

  // One clock of stimulus: inputs change at the falling edge, the model predicts the next rising edge.
  task automatic cyc(input bit r, input bit t, input bit n, input bit [1:0] q);
    bit was;
    @(negedge clk);
    bus.tick    = t;
    bus.night   = n;
    bus.ped_req = q;
    if (r) begin
      was = ret;
      ret = 1'b1;
      m_reset();
      if (!was) begin
        #1;
        check("rst_now_light1", int'(bus.light1), 3'b010);
        check("rst_now_light2", int'(bus.light2), 3'b010);
        check("rst_now_phase",  int'(bus.phase),  int'(ST_ALLY));
        check("rst_now_remain", int'(bus.remain), P_ALLY - 1);
        check("rst_now_pend",   int'(bus.ped_pend), 0);
      end
    end else begin
      ret = 1'b0;
      m_step(t, n, q);
    end
    push_exp();
  endtask

  task automatic run_until(input tl_state_e s, input int el);
    int k;
    k = 0;
    while (!(m_st == s && m_el == el) && k < 200) begin
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      k++;
    end
    check("seq_reach", (m_st == s && m_el == el) ? 1 : 0, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("phase",    int'(bus.phase),    e.ph);
        check("light1",   int'(bus.light1),   e.l1);
        check("light2",   int'(bus.light2),   e.l2);
        check("remain",   int'(bus.remain),   e.rem);
        check("ped_pend", int'(bus.ped_pend), e.pend);
      end
    end
  end

  initial begin
    bit nt;
    bit rr;
    bus.tick    = 1'b0;
    bus.night   = 1'b0;
    bus.ped_req = 2'b00;
    m_reset();

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'b00);
    repeat (32) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    run_until(ST_G1R2, 0);
    cyc(1'b0, 1'b1, 1'b0, 2'b01);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    run_until(ST_R1G2, 5);
    cyc(1'b0, 1'b1, 1'b0, 2'b10);
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    // Request on the exit edge itself must be dropped.
    run_until(ST_G1R2, 1);
    cyc(1'b0, 1'b1, 1'b0, 2'b01);
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 2'b01);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    run_until(ST_Y1R2, 1);
    repeat (7) cyc(1'b0, 1'b1, 1'b1, 2'b11);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    run_until(ST_G1R2, 4);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b01);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'b00);
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    run_until(ST_G1R2, 6);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 2'b00);
    repeat (30) cyc(1'b0, 1'b1, 1'b0, 2'b00);

    nt = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) nt = ~nt;
      rr = ($urandom_range(0, 999) == 0);
      cyc(rr, $urandom_range(0, 3) != 0, nt,
          {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter CNT_W, default 12: width of the phase counter and remaining-time output.
REQ-002 Parameter T_ALLY, default 250: ticks in the start-up/recovery all-yellow phase.
REQ-003 Parameter T_Y, default 250: ticks in each single-direction yellow phase.
REQ-004 Parameter T_G1, default 2500: ticks in the full green phase for direction 1.
REQ-005 Parameter T_G2, default 2250: ticks in the full green phase for direction 2.
REQ-006 Parameter T_MIN, default 500: minimum green ticks before a pedestrian request may end the green phase.
REQ-007 Parameter T_FLASH, default 50: ticks per on/off half-period in night flash.
REQ-008 clk  input  1  single clock; all state changes on the rising edge.
REQ-009 ret  input  1  asynchronous, active-high reset.
REQ-010 tick  input  1  time-base enable; phase timing advances only on clk edges where tick=1.
REQ-011 night  input  1  level; 1 requests flashing-yellow night mode.
REQ-012 ped_req  input  2  one-cycle request pulses; bit0 asks direction 1 to stop, bit1 asks direction 2 to stop.
REQ-013 light1  output  3  registered lamps for direction 1, {red,yellow,green}.
REQ-014 light2  output  3  registered lamps for direction 2, {red,yellow,green}.
REQ-015 phase  output  3  current state encoding.
REQ-016 remain  output  CNT_W  ticks left in the current timed phase, 0 in FLASH.
REQ-017 ped_pend  output  2  latched, not-yet-served pedestrian requests.

Function
REQ-018 The states SHALL be ALLY, R1Y2, G1R2, Y1R2, R1G2 and FLASH.
REQ-019 Lamps per state SHALL be: ALLY Y/Y; R1Y2 R/Y; G1R2 G/R; Y1R2 Y/R; R1G2 R/G; FLASH both yellow when the flash phase bit is 1, all off when it is 0.
REQ-020 Normal cycle SHALL be ALLY -> R1Y2 -> G1R2 -> Y1R2 -> R1G2 -> R1Y2 -> G1R2.
REQ-021 The phase counter SHALL clear on entry to each state, increment on each tick, and trigger the transition on the tick where count = T-1, so each state lasts exactly T ticks.
REQ-022 Lamps and phase SHALL update on the same clock edge as the state transition, with no extra latency.
REQ-023 remain SHALL equal T-1-count for the current state.
REQ-024 A ped_req bit SHALL set its ped_pend bit on any clock edge, whether or not tick is high.
REQ-025 In G1R2 with ped_pend[0]=1 and count >= T_MIN-1, the next tick SHALL move to Y1R2; R1G2 with ped_pend[1]=1 behaves the same way toward R1Y2.
REQ-026 ped_pend[0] SHALL clear on leaving G1R2, and ped_pend[1] SHALL clear on leaving R1G2, whether the exit was natural or forced.
REQ-027 A request arriving on the same edge as its bit is cleared SHALL be dropped.
REQ-028 With night=1 on a tick, the next state SHALL be FLASH from any state, overriding expiry and pedestrian requests, and ped_pend SHALL clear.
REQ-029 In FLASH, the flash phase bit SHALL start at 1 and toggle every T_FLASH ticks, and ped_req SHALL be ignored.
REQ-030 With night=0 on a tick while in FLASH, the next state SHALL be ALLY with the counter cleared.
REQ-031 With tick=0, state, counter and lamps SHALL hold.
REQ-032 An illegal phase encoding SHALL recover to ALLY with the counter at 0.
REQ-033 Every T_* parameter SHALL be >= 1 and < 2^CNT_W, and T_MIN SHALL be <= min(T_G1,T_G2); violations are a elaboration error.

Reset
REQ-034 While ret=1, regardless of clk: state=ALLY, count=0, light1=light2=3'b010, ped_pend=0, flash bit=1, remain=T_ALLY-1.
REQ-035 Reset asserted mid-phase SHALL abandon the phase, and the first tick after release SHALL be tick 0 of ALLY.

Structure
REQ-036 State encodings and lamp bit positions SHALL reside in the shared package tl_pkg.
REQ-037 An optional sub-module tl_tick_div (parameter DIV) SHALL generate tick from clk, and it is instantiated outside this block.

Verification (T_ALLY=2, T_Y=3, T_G1=10, T_G2=8, T_MIN=4, T_FLASH=2, tick=1 every cycle)
REQ-038 Release reset -> ALLY for 2 cycles, R1Y2 for 3, G1R2 for 10, Y1R2 for 3, R1G2 for 8, then R1Y2.
REQ-039 ped_req=01 on cycle 1 of G1R2 -> Y1R2 entered after 4 G1R2 cycles, and ped_pend[0] clears on that edge.
REQ-040 ped_req=10 on cycle 6 of R1G2 -> R1Y2 entered on the next cycle, and ped_pend[1] clears.
REQ-041 night=1 during Y1R2 -> FLASH on the next cycle, lamps 010/010 for 2 cycles then 000/000; night=0 -> ALLY for 2 cycles.
REQ-042 tick held 0 for 5 cycles mid-G1R2 -> state, lamps and remain frozen, and a ped_req in that window is latched.
REQ-043 ret pulsed on cycle 7 of G1R2 -> lamps 010/010 immediately, and the normal sequence restarts from ALLY.
